branch_unit: RTL and testbench

- Consumer stage directly downstream of the flag comparer: samples the registered lt/gt/eq flags and resolves conditional jump, call and return instructions.
- Produces the next program counter for the fetch stage.
- Holds a hardware return-address stack with overflow and underflow detection.
- Sequenced by a start/done handshake issued by the control unit in the same cycle it pulses the comparer's start.

---
 rtl/branch_unit.sv | 162 ++++++++++++++++
 tb/tb_branch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Branch resolver downstream of the flag comparer: evaluates jump/call/return
// conditions on the registered lt/gt/eq flags and maintains a return-address stack.
module branch_unit #(
    parameter int AW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [2:0]              cond,
    input  logic [AW-1:0]           pc,
    input  logic [AW-1:0]           target,
    input  logic                    lt,
    input  logic                    gt,
    input  logic                    eq,
    input  logic                    err_clr,
    output logic                    busy,
    output logic                    done,
    output logic                    take,
    output logic [AW-1:0]           next_pc,
    output logic [1:0]              err,
    output logic [$clog2(DEPTH):0]  sp
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] SP_FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    localparam logic [1:0] OP_JMP  = 2'd0;
    localparam logic [1:0] OP_CALL = 2'd1;
    localparam logic [1:0] OP_RET  = 2'd2;

    state_t          state_q;
    logic [1:0]      op_q;
    logic [2:0]      cond_q;
    logic [AW-1:0]   pc_q, target_q;
    logic            busy_q, done_q, take_q;
    logic [AW-1:0]   next_pc_q;
    logic [1:0]      err_q;
    logic [PW:0]     sp_q;
    logic [AW-1:0]   mem_q [DEPTH];

    logic            cond_true;
    logic [AW-1:0]   pc_inc;
    logic            take_d;
    logic [AW-1:0]   next_pc_d;
    logic            push, pop;
    logic [1:0]      err_set;
    logic [PW-1:0]   rd_idx;

    always_comb begin
        case (cond_q)
            3'd0:    cond_true = 1'b0;
            3'd1:    cond_true = 1'b1;
            3'd2:    cond_true = eq;
            3'd3:    cond_true = !eq;
            3'd4:    cond_true = lt;
            3'd5:    cond_true = gt;
            3'd6:    cond_true = lt | eq;
            default: cond_true = gt | eq;
        endcase
        pc_inc    = pc_q + AW'(1);
        rd_idx    = sp_q[PW-1:0] - PW'(1);
        take_d    = 1'b0;
        next_pc_d = pc_inc;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 2'b00;
        // Flags are only meaningful in EVAL, one cycle after the comparer started.
        if (state_q == S_EVAL && cond_true) begin
            case (op_q)
                OP_JMP: begin
                    take_d    = 1'b1;
                    next_pc_d = target_q;
                end
                OP_CALL: begin
                    if (sp_q != SP_FULL) begin
                        push      = 1'b1;
                        take_d    = 1'b1;
                        next_pc_d = target_q;
                    end else begin
                        err_set[0] = 1'b1;
                    end
                end
                OP_RET: begin
                    if (sp_q != '0) begin
                        pop       = 1'b1;
                        take_d    = 1'b1;
                        next_pc_d = mem_q[rd_idx];
                    end else begin
                        err_set[1] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cond_q    <= '0;
            pc_q      <= '0;
            target_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            take_q    <= 1'b0;
            next_pc_q <= '0;
            err_q     <= '0;
            sp_q      <= '0;
        end else begin
            done_q <= 1'b0;
            // A coinciding new error wins over the clear.
            err_q  <= (err_clr ? 2'b00 : err_q) | err_set;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        cond_q   <= cond;
                        pc_q     <= pc;
                        target_q <= target;
                        busy_q   <= 1'b1;
                        state_q  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    take_q    <= take_d;
                    next_pc_q <= next_pc_d;
                    if (push)
                        sp_q <= sp_q + (PW+1)'(1);
                    else if (pop)
                        sp_q <= sp_q - (PW+1)'(1);
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stack contents need no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[sp_q[PW-1:0]] <= pc_inc;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign take    = take_q;
    assign next_pc = next_pc_q;
    assign err     = err_q;
    assign sp      = sp_q;
endmodule

// File: tb/tb_branch_unit.sv
// Directed and randomized checks of branch_unit against a queue-based reference model.
module tb_branch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [2:0]  cond = '0;
    logic [15:0] pc = '0;
    logic [15:0] target = '0;
    logic        lt = 1'b0, gt = 1'b0, eq = 1'b0;
    logic        err_clr = 1'b0;
    logic        busy, done, take;
    logic [15:0] next_pc;
    logic [1:0]  err;
    logic [3:0]  sp;

    int checks = 0;
    int errors = 0;

    logic [15:0] stk[$];
    logic [1:0]  m_err = 2'b00;
    logic        m_take = 1'b0;
    logic [15:0] m_npc = 16'h0000;

    branch_unit #(.AW(16), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .cond(cond),
        .pc(pc), .target(target), .lt(lt), .gt(gt), .eq(eq),
        .err_clr(err_clr), .busy(busy), .done(done), .take(take),
        .next_pc(next_pc), .err(err), .sp(sp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // r: comparison relation seen by the comparer (-1 less, 0 equal, +1 greater)
    function automatic bit cond_holds(input int c, input int r);
        case (c)
            0: return 1'b0;
            1: return 1'b1;
            2: return r == 0;
            3: return r != 0;
            4: return r < 0;
            5: return r > 0;
            6: return r <= 0;
            default: return r >= 0;
        endcase
    endfunction

    task automatic model(input int o, input int c, input logic [15:0] p,
                         input logic [15:0] t, input int r, input bit clr);
        logic [15:0] p1;
        bit ct;
        p1 = p + 16'd1;
        ct = cond_holds(c, r);
        if (clr) m_err = 2'b00;
        m_take = 1'b0;
        m_npc  = p1;
        if (ct && o == 0) begin
            m_take = 1'b1; m_npc = t;
        end else if (ct && o == 1) begin
            if (stk.size() < 8) begin
                stk.push_back(p1); m_take = 1'b1; m_npc = t;
            end else m_err[0] = 1'b1;
        end else if (ct && o == 2) begin
            if (stk.size() > 0) begin
                m_npc = stk.pop_back(); m_take = 1'b1;
            end else m_err[1] = 1'b1;
        end
    endtask

    task automatic branch(input int o, input int c, input logic [15:0] p,
                          input logic [15:0] t, input int r, input bit clr_eval,
                          input bit hold_start);
        logic [3:0] sp_after;
        @(negedge clk);
        start = 1'b1; op = 2'(o); cond = 3'(c); pc = p; target = t;
        lt = 1'($urandom); gt = 1'($urandom); eq = 1'($urandom);
        @(negedge clk);
        chk("eval_busy", busy, 1);
        chk("eval_done", done, 0);
        start = hold_start;
        lt = (r < 0); gt = (r > 0); eq = (r == 0);
        err_clr = clr_eval;
        model(o, c, p, t, r, clr_eval);
        @(negedge clk);
        err_clr = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("take", take, m_take);
        chk("next_pc", next_pc, m_npc);
        chk("sp", sp, 32'(stk.size()));
        chk("err", err, m_err);
        $display("txn op=%0d cond=%0d pc=%04h tgt=%04h r=%0d -> take=%0d next_pc=%04h sp=%0d err=%b",
                 o, c, p, t, r, take, next_pc, sp, err);
        sp_after = sp;
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("hold_take", take, m_take);
        chk("hold_npc", next_pc, m_npc);
        start = 1'b0;
        if (hold_start) begin
            repeat (3) begin
                @(negedge clk);
                chk("ignored_start_done", done, 0);
                chk("ignored_start_sp", sp, sp_after);
            end
        end
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 2'b00;
        chk("err_clr", err, m_err);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_take", take, 0);
        chk("rst_npc", next_pc, 0);
        chk("rst_sp", sp, 0);
        chk("rst_err", err, 0);

        // JMP on lt, taken then not taken
        branch(0, 4, 16'h0100, 16'h0200, -1, 0, 0);
        branch(0, 4, 16'h0100, 16'h0200, 1, 0, 0);

        // CALL then RET
        branch(1, 1, 16'h0010, 16'h0400, 0, 0, 0);
        branch(2, 1, 16'h0400, 16'h0000, 0, 0, 0);
        chk("ret_addr", next_pc, 16'h0011);

        // Overflow on ninth CALL, clear, coincident clear+overflow, underflow
        for (int i = 0; i < 9; i++)
            branch(1, 1, 16'(16'h1000 + i * 16), 16'(16'h2000 + i), 0, 0, 0);
        chk("ovf_err", err, 2'b01);
        chk("ovf_sp", sp, 8);
        clear_err();
        branch(1, 1, 16'h3000, 16'h3100, 0, 1, 0);
        chk("clr_vs_new_err", err, 2'b01);
        clear_err();
        for (int i = 0; i < 9; i++)
            branch(2, 1, 16'(16'h4000 + i), 16'h0000, 0, 0, 0);
        chk("unf_err", err, 2'b10);
        clear_err();

        // Condition sweep with one-hot flag sets
        for (int c = 0; c < 8; c++)
            for (int r = -1; r <= 1; r++)
                branch(0, c, 16'(16'h0500 + c), 16'(16'h0A00 + c), r, 0, 0);

        // pc wrap, reserved op, start held while busy
        branch(0, 0, 16'hFFFF, 16'h1234, 0, 0, 0);
        chk("wrap_npc", next_pc, 16'h0000);
        branch(3, 1, 16'h0700, 16'h0800, 0, 0, 0);
        branch(1, 1, 16'h0020, 16'h0600, 1, 0, 1);

        // Reset during EVAL aborts without a push
        @(negedge clk);
        start = 1'b1; op = 2'd1; cond = 3'd1; pc = 16'h0030; target = 16'h0900;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sp", sp, 0);
        chk("mid_rst_npc", next_pc, 0);
        @(negedge clk);
        chk("mid_rst_done", done, 0);
        rst = 1'b1;
        stk.delete();
        m_err = 2'b00; m_take = 1'b0; m_npc = 16'h0000;
        @(negedge clk);
        chk("post_rst_sp", sp, 0);
        chk("post_rst_take", take, 0);

        // Randomized mix against the model
        for (int n = 0; n < 80; n++) begin
            int o, c, r;
            o = (($urandom_range(0, 9) < 4) ? 1 : ($urandom_range(0, 2) == 0 ? 0 : 2));
            if ($urandom_range(0, 19) == 0) o = 3;
            c = int'($urandom_range(0, 7));
            r = int'($urandom_range(0, 2)) - 1;
            branch(o, c, 16'($urandom), 16'($urandom), r, 0, 0);
            if ($urandom_range(0, 9) == 0) clear_err();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
